fetch: RTL and testbench
========================

# fetch

Instruction-fetch stage of the RV32 pipeline, sitting directly upstream of `decode`. It owns the program counter, issues word fetches to instruction memory with at most one request outstanding, and buffers returned instructions with their PCs in a 2-entry FIFO. It presents `{pc, instr, valid}` to decode, honours decode back-pressure, and flushes on a branch/jump redirect from execute.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `FIFO_DEPTH`, default 2: instruction buffer entries; legal values are 2 and 4.
- `clk` in 1: pipeline clock; the same clock drives decode's `req`.
- `reset` in 1: synchronous, active-high.
- `stall_in` in 1: decode not accepting this cycle; tied to decode `rs_read`.
- `redirect_in` in 1: taken branch/jump; flush and refetch.
- `redirect_pc_in` in 32: new PC; bits [1:0] ignored and forced to 0.
- `imem_req_out` out 1: fetch request valid.
- `imem_addr_out` out 32: word-aligned fetch address.
- `imem_ready_in` in 1: memory accepts the request this cycle.
- `imem_rvalid_in` in 1: read data valid; responses are in order and arrive ≥1 cycle after acceptance.
- `imem_rdata_in` in 32: instruction word.
- `instr_out` out 32: FIFO head instruction to decode `instr_in`.
- `pc_out` out 32: FIFO head PC to decode `pc_in_dec`.
- `valid_out` out 1: head valid.

## Operation
- Reset values: state IDLE, `fetch_pc = RESET_PC`, FIFO empty, `imem_req_out = 0`, `imem_addr_out = RESET_PC`, `valid_out = 0`, `instr_out = 0`, `pc_out = 0`.
- FSM states:
  - IDLE: goes to REQ on the next cycle.
  - REQ: asserts `imem_req_out` with `imem_addr_out = fetch_pc` when `count + outstanding < FIFO_DEPTH`, otherwise holds req low. A handshake (`imem_req_out && imem_ready_in`) latches the request PC, sets `fetch_pc += 4`, and moves to WAIT.
  - WAIT: on `imem_rvalid_in`, push `{req_pc, imem_rdata_in}` and return to REQ.
  - DROP: discard the next `imem_rvalid_in`, then go to REQ.
- Pop: when `valid_out && !stall_in`. Push and pop may occur in the same cycle. The issue rule guarantees a push never occurs into a full FIFO; a push while full is an assertion failure.
- Redirect has priority over all other events in the cycle:
  - The FIFO is flushed, including any same-cycle push or pop.
  - `fetch_pc <= {redirect_pc_in[31:2], 2'b00}`.
  - `valid_out` is forced to 0 in the redirect cycle.
  - Next state by current state:
    - REQ with handshake: DROP, because the old-PC request is now outstanding.
    - REQ without handshake: REQ.
    - WAIT with rvalid: REQ, response discarded.
    - WAIT without rvalid: DROP.
    - DROP with rvalid: REQ.
    - DROP without rvalid: DROP.
    - IDLE: IDLE.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0.
- Reset mid-operation: state and FIFO return to reset values, and any in-flight response is ignored. Memory is reset together with fetch, so no stale rvalid follows.

## Timing
- The FIFO head is registered. `valid_out`, `instr_out` and `pc_out` change only on `clk` edges, apart from the combinational redirect kill on `valid_out`.
- First fetch:
  - cycle 0 is the first cycle with `reset` low (IDLE);
  - cycle 1 asserts `imem_req_out`;
  - with zero-wait memory (ready at cycle 1, rvalid at cycle 2), `valid_out` rises at cycle 3.
- Throughput is one instruction per 2 cycles with zero-wait memory, because of the single outstanding request.
- Redirect to first refetch request is 1 cycle (REQ path). If the redirect sends the FSM to DROP, the delay is 1 cycle plus the remaining memory latency.
- `imem_addr_out` is held stable while `imem_req_out` is high and not accepted, except on redirect.

## Structure
- Package `fetch_pkg`:
  - `typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} fetch_state_t`;
  - `localparam PC_STEP = 32'd4`;
  - `typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t`.
- Sub-module `fetch_fifo`:
  - parameterised depth, storing `fetch_entry_t`;
  - push/pop/flush ports, `count`, registered head.
  - Flush takes priority over push and pop.

## Test plan
- Reset with `RESET_PC` = 32'h100 and zero-wait memory returning addr^32'hA5A5_0000, no stall: requests at 0x100, 0x104, 0x108; `pc_out`/`instr_out` pairs match in order; first `valid_out` at cycle 3.
- Hold `stall_in` high for 10 cycles: FIFO fills to 2, `imem_req_out` stays low; on release, the entries drain in order with no loss or duplication.
- Redirect to 32'h200 while in WAIT: a late rvalid carrying 0x10C data is discarded, the next request is 0x200, and 0x10C never appears on `pc_out`.
- Redirect to 32'h203 in the same cycle as rvalid: response discarded, FIFO flushed, `valid_out` 0 that cycle, next request 32'h200.
- Redirect to 32'hFFFF_FFFC: requests 0xFFFF_FFFC then 0x0000_0000.
- Assert `reset` for 1 cycle with 2 entries buffered and one request outstanding: all outputs take their reset values next cycle, and fetching restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32 instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} fetch_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between fetch (master) and imem (slave).
interface fetch_if;

    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ready_in;
    logic        imem_rvalid_in;
    logic [31:0] imem_rdata_in;

    modport master (
        output imem_req_out, imem_addr_out,
        input  imem_ready_in, imem_rvalid_in, imem_rdata_in
    );

    modport slave (
        input  imem_req_out, imem_addr_out,
        output imem_ready_in, imem_rvalid_in, imem_rdata_in
    );

endinterface

// File: rtl/fetch_fifo.sv
// Shift-register instruction buffer with a registered head entry; flush beats push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  push_data,
    output fetch_entry_t  head,
    output logic          head_valid,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  head_q;
    fetch_entry_t  tail_q [DEPTH-1];
    fetch_entry_t  ent    [DEPTH];
    fetch_entry_t  ent_n  [DEPTH];
    logic [CW-1:0] count_n;
    logic [CW-1:0] base;

    always_comb begin
        ent[0] = head_q;
        for (int i = 1; i < DEPTH; i++) ent[i] = tail_q[i-1];
    end

    // NOTE: every variable gets a default before any branch so no path leaves it unassigned and infers a latch.
    always_comb begin
        ent_n   = ent;
        count_n = count;
        base    = count;
        if (flush) begin
            count_n = '0;
        end else begin
            if (pop && count != '0) begin
                for (int i = 0; i < DEPTH - 1; i++) ent_n[i] = ent[i+1];
                base = count - 1'b1;
            end
            if (push && base < CW'(DEPTH)) ent_n[base[AW-1:0]] = push_data;
            count_n = base + CW'(push);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            head_q <= '0;
        end else begin
            count  <= count_n;
            head_q <= ent_n[0];
        end
    end

    // NOTE: storage behind the head is deliberately not reset; count alone decides which entries are live.
    always_ff @(posedge clk) begin
        for (int i = 1; i < DEPTH; i++) tail_q[i-1] <= ent_n[i];
    end

    assign head       = head_q;
    assign head_valid = (count != '0);

    push_into_full: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && !flush && count == CW'(DEPTH)));

endmodule

// File: rtl/fetch.sv
// RV32 fetch stage: owns the PC, keeps one imem request in flight, buffers results for decode.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall_in,
    input  logic         redirect_in,
    input  logic [31:0]  redirect_pc_in,
    fetch_if.master      imem,
    output logic [31:0]  instr_out,
    output logic [31:0]  pc_out,
    output logic         valid_out
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_REQ  = REQ;
    localparam logic [1:0] ST_WAIT = WAIT;
    localparam logic [1:0] ST_DROP = DROP;

    logic [1:0]    state, state_n;
    logic [31:0]   fetch_pc, req_pc;
    logic          handshake, push, pop, head_valid;
    logic [CW-1:0] count;
    fetch_entry_t  head, push_data;

    // Nothing is outstanding while in REQ, so the issue rule reduces to free FIFO space.
    assign imem.imem_req_out  = (state == ST_REQ) && (count < CW'(FIFO_DEPTH));
    assign imem.imem_addr_out = fetch_pc;

    assign handshake = imem.imem_req_out && imem.imem_ready_in;
    assign push      = (state == ST_WAIT) && imem.imem_rvalid_in && !redirect_in;
    assign pop       = head_valid && !stall_in;

    assign push_data.pc    = req_pc;
    assign push_data.instr = imem.imem_rdata_in;

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: state_n = redirect_in ? ST_IDLE : ST_REQ;
            ST_REQ:  if (handshake) state_n = redirect_in ? ST_DROP : ST_WAIT;
            ST_WAIT: begin
                if (imem.imem_rvalid_in) state_n = ST_REQ;
                else if (redirect_in)    state_n = ST_DROP;
            end
            ST_DROP: if (imem.imem_rvalid_in) state_n = ST_REQ;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            state <= state_n;
            if (redirect_in)    fetch_pc <= align_pc(redirect_pc_in);
            else if (handshake) fetch_pc <= fetch_pc + PC_STEP;
            if (handshake)      req_pc   <= fetch_pc;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_in),
        .push_data  (push_data),
        .head       (head),
        .head_valid (head_valid),
        .count      (count)
    );

    // The redirect kill is the only combinational path onto the decode-facing outputs.
    assign valid_out = head_valid && !redirect_in;
    assign instr_out = head.instr;
    assign pc_out    = head.pc;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: imem model plus a scoreboard of expected {pc, instr} pairs.
module tb_fetch;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h100;
    localparam logic [31:0] KEY    = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset, stall_in, redirect_in;
    logic [31:0] redirect_pc_in, instr_out, pc_out;
    logic        valid_out;

    fetch_if imem ();

    fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall_in       (stall_in),
        .redirect_in    (redirect_in),
        .redirect_pc_in (redirect_pc_in),
        .imem           (imem),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .valid_out      (valid_out)
    );

    always #5 clk = ~clk;

    int           n_assert, n_fail, cyc, first_valid_cyc, n_acc, lat, pend_cyc;
    fetch_entry_t q [$];
    logic         pend_v, pend_drop, mem_ready, chk_reset, hold_chk;
    logic [31:0]  pend_pc, pend_data, exp_req_pc, hold_addr, last_acc_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle, entered and left just after the falling edge.
    task automatic step();
        fetch_entry_t e;
        logic         resp;
        logic         req;
        logic [31:0]  addr;
        resp = !reset && pend_v && (pend_cyc == cyc);
        imem.imem_ready_in  = mem_ready;
        imem.imem_rvalid_in = resp;
        imem.imem_rdata_in  = resp ? pend_data : 32'h0;
        #1;
        req  = imem.imem_req_out;
        addr = imem.imem_addr_out;
        if (reset) begin
            q.delete();
            pend_v          = 1'b0;
            exp_req_pc      = RST_PC;
            chk_reset       = 1'b1;
            hold_chk        = 1'b0;
            first_valid_cyc = -1;
        end else begin
            if (chk_reset) begin
                check("rst_req",   req,       0);
                check("rst_addr",  addr,      RST_PC);
                check("rst_valid", valid_out, 0);
                check("rst_pc",    pc_out,    0);
                check("rst_instr", instr_out, 0);
                chk_reset = 1'b0;
            end
            if (redirect_in) check("redirect_kill", valid_out, 0);
            if (hold_chk) begin
                check("hold_req",  req,  1);
                check("hold_addr", addr, hold_addr);
            end
            check("one_outstanding", req && pend_v, 0);
            if (valid_out && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (valid_out && !stall_in) begin
                if (q.size() == 0) begin
                    check("unexpected_valid", valid_out, 0);
                end else begin
                    e = q.pop_front();
                    check("pc_out",    pc_out,    e.pc);
                    check("instr_out", instr_out, e.instr);
                end
            end
            hold_chk  = req && !mem_ready && !redirect_in;
            hold_addr = addr;
            if (resp) begin
                pend_v = 1'b0;
                if (!pend_drop && !redirect_in) begin
                    e.pc    = pend_pc;
                    e.instr = pend_pc ^ KEY;
                    q.push_back(e);
                end
            end
            if (redirect_in) begin
                q.delete();
                pend_drop = 1'b1;
            end
            if (req && mem_ready) begin
                check("req_addr", addr, exp_req_pc);
                pend_v        = 1'b1;
                pend_pc       = exp_req_pc;
                pend_data     = addr ^ KEY;
                pend_cyc      = cyc + lat;
                pend_drop     = redirect_in;
                last_acc_addr = addr;
                exp_req_pc    = exp_req_pc + 32'd4;
                n_acc++;
            end
            if (redirect_in) exp_req_pc = redirect_pc_in & ~32'h3;
        end
        @(posedge clk);
        cyc = reset ? 0 : cyc + 1;
        @(negedge clk);
    endtask

    task automatic wait_acc(input string tag, input logic [31:0] exp_addr);
        int n0;
        logic got;
        n0  = n_acc;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            step();
            got = (n_acc > n0);
        end
        check({tag, "_seen"}, got, 1);
        check(tag, last_acc_addr, exp_addr);
    endtask

    initial begin
        logic found;
        n_assert = 0; n_fail = 0; cyc = 0; n_acc = 0; lat = 1; pend_cyc = 0;
        first_valid_cyc = -1;
        reset = 1'b1; stall_in = 1'b0; redirect_in = 1'b0; redirect_pc_in = 32'h0;
        mem_ready = 1'b1; pend_v = 1'b0; pend_drop = 1'b0; chk_reset = 1'b0; hold_chk = 1'b0;
        pend_pc = 32'h0; pend_data = 32'h0; exp_req_pc = RST_PC; hold_addr = 32'h0;
        last_acc_addr = 32'h0;
        imem.imem_ready_in = 1'b0; imem.imem_rvalid_in = 1'b0; imem.imem_rdata_in = 32'h0;
        @(negedge clk);
        repeat (3) step();
        reset = 1'b0;

        // Zero-wait streaming from RESET_PC.
        repeat (12) step();
        check("first_valid_cycle", first_valid_cyc, 3);

        // Back-pressure: FIFO fills and requests stop, then drains in order.
        stall_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i >= 6) begin
                check("stall_req_low", imem.imem_req_out, 0);
                check("stall_valid",   valid_out,         1);
            end
            step();
        end
        stall_in = 1'b0;
        repeat (10) step();

        // Redirect while waiting on a slow response.
        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (pend_v && !pend_drop && pend_cyc > cyc) found = 1'b1;
            else step();
        end
        check("t3_reach_wait", found, 1);
        redirect_in = 1'b1; redirect_pc_in = 32'h200;
        step();
        redirect_in = 1'b0;
        wait_acc("t3_refetch", 32'h200);
        lat = 1;
        repeat (10) step();

        // Redirect to an unaligned PC in the same cycle as a response, FIFO non-empty.
        stall_in = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (valid_out && pend_v && !pend_drop && pend_cyc == cyc) found = 1'b1;
            else step();
        end
        check("t4_reach_rvalid", found, 1);
        redirect_in = 1'b1; redirect_pc_in = 32'h203;
        step();
        redirect_in = 1'b0; stall_in = 1'b0;
        check("t4_flushed", valid_out, 0);
        wait_acc("t4_refetch", 32'h200);
        repeat (6) step();

        // PC wrap-around.
        redirect_in = 1'b1; redirect_pc_in = 32'hFFFF_FFFC;
        step();
        redirect_in = 1'b0;
        wait_acc("t5_top", 32'hFFFF_FFFC);
        wait_acc("t5_wrap", 32'h0000_0000);
        repeat (8) step();

        // Reset with buffered entries and a request in flight.
        lat = 3; stall_in = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (valid_out && pend_v && !pend_drop) found = 1'b1;
            else step();
        end
        check("t6_reach_busy", found, 1);
        reset = 1'b1;
        step();
        reset = 1'b0; stall_in = 1'b0; lat = 1;
        step();
        wait_acc("t6_restart", RST_PC);
        repeat (6) step();
        check("t6_first_valid", first_valid_cyc, 3);

        // Random stall, memory wait states, latency and redirects.
        for (int i = 0; i < 300; i++) begin
            stall_in       = ($urandom_range(0, 9) < 3);
            mem_ready      = ($urandom_range(0, 9) < 7);
            lat            = $urandom_range(1, 3);
            redirect_in    = ($urandom_range(0, 99) < 4);
            redirect_pc_in = $urandom;
            step();
        end
        redirect_in = 1'b0; stall_in = 1'b0; mem_ready = 1'b1; lat = 1;
        repeat (12) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
